// File: rtl/canny_hysteresis.sv
`default_nettype none
// ============================================================================
// Module   : canny_hysteresis
// Purpose  : Double threshold plus single-pass 8-neighbour hysteresis over a
//            raster stream of NMS magnitudes; emits a 1-bit edge map.
//            Build macro CANNY_HYST_EN enables WEAK-to-edge promotion.
// Revision : 1.0 - initial release
// ============================================================================
module canny_hysteresis #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] mag,
  input  logic [15:0] t_low,
  input  logic [15:0] t_high,
  output logic        edge_out,
  output logic        out_valid,
  output logic        out_last
);

  localparam int c_CW = $clog2(IMG_W);
  localparam int c_RW = $clog2(IMG_H + 2);
  localparam logic [c_CW-1:0] c_LAST_COL  = c_CW'(IMG_W - 1);
  localparam logic [c_CW-1:0] c_COL1      = c_CW'(1);
  localparam logic [c_RW-1:0] c_LAST_ROW  = c_RW'(IMG_H - 1);
  localparam logic [c_RW-1:0] c_FLUSH_ROW = c_RW'(IMG_H);
  localparam logic [c_RW-1:0] c_END_ROW   = c_RW'(IMG_H + 1);
  localparam logic [c_RW-1:0] c_ROW1      = c_RW'(1);
  localparam logic [c_RW-1:0] c_ROW2      = c_RW'(2);
  localparam logic [1:0]      c_NONE      = 2'd0;
  localparam logic [1:0]      c_WEAK      = 2'd1;
  localparam logic [1:0]      c_STRONG    = 2'd2;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t          r_state;
  logic            r_in_ready;
  logic [c_CW-1:0] r_col;
  logic [c_RW-1:0] r_row;
  logic [15:0]     r_tl;
  logic [15:0]     r_th;
  logic [1:0]      r_lb0 [IMG_W];
  logic [1:0]      r_lb1 [IMG_W];
  logic [1:0]      r_win [3][3];
  logic [c_CW-1:0] r_ccol;
  logic [c_RW-1:0] r_crow;
  logic            r_cvld;

  logic            w_accept, w_inject, w_adv, w_first, w_wrap, w_cvld, w_dec;
  logic [15:0]     w_tl, w_th, w_tl_eff;
  logic [1:0]      w_cls;
  logic [c_CW-1:0] w_ccol;
  logic [c_RW-1:0] w_crow;

  assign in_ready = r_in_ready;
  assign w_accept = in_valid && r_in_ready;
  assign w_inject = (r_state == S_FLUSH);
  assign w_adv    = w_accept || w_inject;
  assign w_first  = (r_col == '0) && (r_row == '0);

  // The first pixel of a frame is classified against the thresholds being sampled.
  assign w_th     = w_first ? t_high : r_th;
  assign w_tl     = w_first ? t_low  : r_tl;
  assign w_tl_eff = (w_tl > w_th) ? w_th : w_tl;
  assign w_cls    = w_inject           ? c_NONE   :
                    (mag >= w_th)      ? c_STRONG :
                    (mag >= w_tl_eff)  ? c_WEAK   : c_NONE;

  // Center lags the newest input by IMG_W+1 stream positions.
  assign w_wrap = (r_col == '0);
  assign w_ccol = w_wrap ? c_LAST_COL : r_col - c_COL1;
  assign w_crow = w_wrap ? r_row - c_ROW2 : r_row - c_ROW1;
  assign w_cvld = (r_row >= c_ROW2) || ((r_row == c_ROW1) && !w_wrap);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_in_ready <= 1'b1;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      if (w_adv) begin
        if (r_col == c_LAST_COL) begin
          r_col <= '0;
          r_row <= r_row + c_ROW1;
        end else begin
          r_col <= r_col + c_COL1;
        end
      end
      case (r_state)
        S_IDLE: if (w_accept) r_state <= S_RUN;
        S_RUN: begin
          if (w_accept && r_row == c_LAST_ROW && r_col == c_LAST_COL) begin
            r_state    <= S_FLUSH;
            r_in_ready <= 1'b0;
          end
        end
        S_FLUSH: begin
          if (r_row == c_END_ROW && r_col == '0) begin
            r_state    <= S_IDLE;
            r_in_ready <= 1'b1;
            r_col      <= '0;
            r_row      <= '0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tl <= '0;
      r_th <= '0;
    end else if (w_accept && w_first) begin
      r_tl <= t_low;
      r_th <= t_high;
    end
  end

  // Line buffers hold no reset; stale entries are always masked at the borders.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= w_cls;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 3; r++)
          r_win[c][r] <= c_NONE;
      r_ccol <= '0;
      r_crow <= '0;
      r_cvld <= 1'b0;
    end else begin
      r_cvld <= w_adv && w_cvld;
      if (w_adv) begin
        r_win[0]    <= r_win[1];
        r_win[1]    <= r_win[2];
        r_win[2][0] <= r_lb1[r_col];
        r_win[2][1] <= r_lb0[r_col];
        r_win[2][2] <= w_cls;
        r_ccol      <= w_ccol;
        r_crow      <= w_crow;
      end
    end
  end

`ifdef CANNY_HYST_EN
  logic w_nb_strong;
  always_comb begin
    w_nb_strong = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int r = 0; r < 3; r++) begin
        if (!(c == 1 && r == 1) &&
            !(c == 0 && r_ccol == '0) && !(c == 2 && r_ccol == c_LAST_COL) &&
            !(r == 0 && r_crow == '0) && !(r == 2 && r_crow == c_LAST_ROW) &&
            (r_win[c][r] == c_STRONG))
          w_nb_strong = 1'b1;
      end
    end
  end
  assign w_dec = (r_win[1][1] == c_STRONG) || ((r_win[1][1] == c_WEAK) && w_nb_strong);
`else
  assign w_dec = (r_win[1][1] == c_STRONG);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_out  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      edge_out  <= r_cvld && w_dec;
      out_valid <= r_cvld;
      out_last  <= r_cvld && (r_crow == c_LAST_ROW) && (r_ccol == c_LAST_COL);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_canny_hysteresis.sv
`default_nettype none
// ============================================================================
// Module   : tb_canny_hysteresis
// Purpose  : Directed self-checking bench for canny_hysteresis (4x3 image).
// Revision : 1.0 - initial release
// ============================================================================
module tb_canny_hysteresis;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] mag = '0, t_low = '0, t_high = '0;
  logic        in_ready, edge_out, out_valid, out_last;

  canny_hysteresis #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .mag(mag), .t_low(t_low), .t_high(t_high),
    .edge_out(edge_out), .out_valid(out_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  q_out[$];
  int          q_cyc[$];
  logic [1:0]  exp_q[$];
  logic [15:0] pix[N];
  int          acc_cyc[N];

  always @(negedge clk) begin
    if (out_valid) begin
      q_out.push_back({out_last, edge_out});
      q_cyc.push_back(cyc);
    end
  end

  function automatic logic [1:0] cls(input logic [15:0] m, input logic [15:0] tl, input logic [15:0] th);
    logic [15:0] tle;
    tle = (tl > th) ? th : tl;
    if (m >= th) return 2'd2;
    if (m >= tle) return 2'd1;
    return 2'd0;
  endfunction

  // Reference model on the whole frame: expected {last, edge} per pixel.
  task automatic model_frame(input logic [15:0] tl, input logic [15:0] th);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        logic [1:0] k;
        logic e;
        k = cls(pix[r*W+c], tl, th);
        e = (k == 2'd2);
`ifdef CANNY_HYST_EN
        if (k == 2'd1)
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if ((dr != 0 || dc != 0) && r+dr >= 0 && r+dr < H && c+dc >= 0 && c+dc < W)
                if (cls(pix[(r+dr)*W+c+dc], tl, th) == 2'd2) e = 1'b1;
`endif
        exp_q.push_back({(r == H-1 && c == W-1), e});
      end
    end
  endtask

  task automatic send_frame(input logic [15:0] tl, input logic [15:0] th,
                            input logic [15:0] tl2, input logic [15:0] th2,
                            input int chg, input int gmax, input int stop_at);
    for (int i = 0; i < N; i++) begin
      int w;
      if (i == stop_at) return;
      repeat ((gmax > 0) ? $urandom_range(0, gmax) : 0) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      mag      = pix[i];
      t_low    = (i >= chg) ? tl2 : tl;
      t_high   = (i >= chg) ? th2 : th;
      w = 0;
      while (!in_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout pixel %0d: in_ready=%b required 1", i, in_ready);
        in_valid = 1'b0;
        return;
      end
      acc_cyc[i] = cyc;
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic check_outputs(input string name, input int n);
    int t;
    t = 0;
    while (q_out.size() < n && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (q_out.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s_count: got %0d outputs required %0d", name, q_out.size(), n);
      q_out.delete();
      q_cyc.delete();
      exp_q.delete();
      return;
    end
    for (int i = 0; i < n; i++) begin
      logic [1:0] got, exp;
      got = q_out.pop_front();
      void'(q_cyc.pop_front());
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s pixel %0d: {last,edge}=%b required %b", name, i, got, exp);
      end
    end
  endtask

  task automatic fill(input logic [15:0] v);
    for (int i = 0; i < N; i++) pix[i] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, edge_out, out_last} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_values: {in_ready,out_valid,edge,last}=%b required 1000",
               {in_ready, out_valid, edge_out, out_last});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_all_zero();
    int n;
    fill(16'd0);
    model_frame(16'd10, 16'd20);
    send_frame(16'd10, 16'd20, 16'd10, 16'd20, N, 0, N);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n !== W + 1) begin
      errors++;
      $display("FAIL flush_ready_low: %0d cycles required %0d", n, W + 1);
    end
    check_outputs("all_zero", N);
    repeat (10) @(negedge clk);
    checks++;
    if (q_out.size() !== 0) begin
      errors++;
      $display("FAIL extra_outputs: got %0d required 0", q_out.size());
    end
  endtask

  task automatic test_single_strong();
    int t;
    fill(16'd0);
    pix[5] = 16'd25;
    model_frame(16'd10, 16'd20);
    send_frame(16'd10, 16'd20, 16'd10, 16'd20, N, 0, N);
    t = 0;
    while (q_cyc.size() < 6 && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (q_cyc.size() < 6 || q_cyc[5] !== acc_cyc[10] + 2) begin
      errors++;
      $display("FAIL latency_1_1: output cycle %0d required %0d",
               (q_cyc.size() < 6) ? -1 : q_cyc[5], acc_cyc[10] + 2);
    end
    check_outputs("single_strong", N);
  endtask

  task automatic test_hyst();
    fill(16'd0);
    pix[5]  = 16'd15;
    pix[10] = 16'd25;
    model_frame(16'd10, 16'd20);
    send_frame(16'd10, 16'd20, 16'd10, 16'd20, N, 0, N);
    check_outputs("hyst", N);
  endtask

  task automatic test_wrap();
    fill(16'd0);
    pix[4] = 16'd15;
    pix[3] = 16'd25;
    model_frame(16'd10, 16'd20);
    send_frame(16'd10, 16'd20, 16'd10, 16'd20, N, 0, N);
    check_outputs("wrap", N);
  endtask

  task automatic test_thresholds();
    fill(16'd25);
    model_frame(16'd30, 16'd20);
    send_frame(16'd30, 16'd20, 16'd0, 16'd100, 4, 0, N);
    check_outputs("inverted_thr", N);
    model_frame(16'd0, 16'd100);
    send_frame(16'd0, 16'd100, 16'd0, 16'd100, N, 0, N);
    check_outputs("new_frame_thr", N);
  endtask

  task automatic test_back_to_back();
    fill(16'd0);
    pix[5]  = 16'd15;
    pix[10] = 16'd25;
    model_frame(16'd10, 16'd20);
    send_frame(16'd10, 16'd20, 16'd10, 16'd20, N, 0, N);
    fill(16'd0);
    pix[0]  = 16'd25;
    pix[11] = 16'd25;
    pix[6]  = 16'd12;
    model_frame(16'd10, 16'd20);
    send_frame(16'd10, 16'd20, 16'd10, 16'd20, N, 0, N);
    check_outputs("back_to_back", 2 * N);
  endtask

  task automatic test_reset_gaps();
    fill(16'd25);
    send_frame(16'd10, 16'd20, 16'd10, 16'd20, N, 2, 5);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    q_out.delete();
    q_cyc.delete();
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (q_out.size() !== 0) begin
      errors++;
      $display("FAIL post_reset_idle: got %0d outputs required 0", q_out.size());
    end
    for (int i = 0; i < N; i++) pix[i] = 16'((i * 7) % 30);
    model_frame(16'd10, 16'd20);
    send_frame(16'd10, 16'd20, 16'd10, 16'd20, N, 2, N);
    check_outputs("gaps_after_reset", N);
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_single_strong();
    test_hyst();
    test_wrap();
    test_thresholds();
    test_back_to_back();
    test_reset_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/canny_hysteresis.md
# canny_hysteresis

Final Canny stage: consumes the raster stream of non-maximum-suppressed magnitudes and applies double thresholding with single-pass 8-neighbour hysteresis, producing a 1-bit edge map. Sits directly downstream of the NMS stage (`mag_nms`/`out_valid`) and feeds the frame writer. Internally it holds two class line buffers, a 3x3 class window and an end-of-frame flush sequencer.

## Interface
- `IMG_W`, default 640: pixels per line (≥3).
- `IMG_H`, default 480: lines per frame (≥3).
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: `mag` holds a pixel.
- `in_ready` output 1: block accepts a pixel this cycle.
- `mag` input 16: NMS magnitude, unsigned.
- `t_low` input 16: weak threshold.
- `t_high` input 16: strong threshold.
- `edge` output 1: edge decision for the current output pixel.
- `out_valid` output 1: `edge` is valid. No backpressure.
- `out_last` output 1: high with the final pixel of a frame.

## Operation
- Accept = `in_valid && in_ready`. Pixels arrive in raster order, IMG_W×IMG_H per frame. Internal `col`/`row` counters advance on accept.
- Thresholds are sampled on the first accepted pixel of a frame (`col==0 && row==0`) and held for the whole frame.
- Classification, computed on accept, gives a 2-bit class:
  - STRONG if `mag >= t_high`.
  - WEAK if `t_low <= mag < t_high`.
  - else NONE.
  - If sampled `t_low > t_high`, `t_low` is treated as `t_high`, so WEAK never occurs.
- The class is written into the line buffers (2×IMG_W entries, 2-bit each) and shifted into the 3x3 window. The window center is the pixel IMG_W+1 positions behind the newest input.
- Window positions outside the image (row −1, row IMG_H, col −1, col IMG_W) read as NONE. The column wrap between lines must not leak neighbours across lines.
- Decision:
  - STRONG center gives `edge=1`.
  - WEAK center gives `edge=1` iff at least one of its 8 neighbours is STRONG (see Configuration).
  - NONE center gives `edge=0`.
- State machine:
  - IDLE: `in_ready=1`. Go to RUN on the first accept.
  - RUN: `in_ready=1`. Go to FLUSH on the accept of pixel (IMG_H−1, IMG_W−1).
  - FLUSH: `in_ready=0`. Injects IMG_W+1 virtual NONE pixels, one per cycle, to drain the window. After the last injection, go to IDLE and clear the counters.
- Exactly IMG_W×IMG_H outputs per frame, in raster order. `out_last` is asserted on output pixel (IMG_H−1, IMG_W−1).

## Timing
- Reset values:
  - `edge=0`, `out_valid=0`, `out_last=0`, `in_ready=1`.
  - State IDLE, counters 0.
  - Line buffers are not cleared; they are masked by the border rule.
- Pipeline:
  - Cycle of accept (or flush injection) of stream index p+IMG_W+1 completes the window for center p.
  - The decision is registered one cycle later.
  - Output p appears exactly 2 cycles after that accept/injection.
- Input gaps (`in_valid=0`) stall the window and counters. The output stream has matching gaps; there is no output without a corresponding accept or injection.
- FLUSH takes exactly IMG_W+1 cycles and ignores `in_valid`. The next frame may be accepted on the cycle the state returns to IDLE. Output of the previous frame's tail may overlap with the new frame's first accepts (pipelined).
- Asynchronous reset mid-frame discards all state. The next accepted pixel is (0,0) of a new frame.

## Configuration
- Macro: `CANNY_HYST_EN`.
- Defined: WEAK pixels are promoted to edge when an 8-neighbour is STRONG, as described above.
- Undefined: pure double threshold. WEAK gives `edge=0`; only STRONG centers give `edge=1`.
  - Line buffers and window are retained, so latency, flush length and handshake are identical in both builds.

## Test plan
- Reset, then IMG_W=4, IMG_H=3, all `mag=0`, `t_low=10`, `t_high=20` → 12 outputs, all `edge=0`. `out_last` on the 12th. `in_ready` low for exactly 5 cycles after the 12th accept.
- Single `mag=25` at (1,1), rest 0 → only output (1,1) has `edge=1`. Output (1,1) appears 2 cycles after the accept of stream index 10.
- `mag=15` at (1,1), `mag=25` at (2,2) → with `CANNY_HYST_EN`: edges at (1,1) and (2,2). Without it: only (2,2).
- WEAK at (1,0) with STRONG at (0,3) (cross-line wrap position) → (1,0) `edge=0` (no wrap leak).
- `t_low=30`, `t_high=20`, `mag=25` everywhere → all 12 outputs `edge=1` (all STRONG). Thresholds changed mid-frame have no effect until the next frame's (0,0).
- Random `in_valid` gaps, two back-to-back frames, `rst_n` pulsed at pixel 5 of the first → no outputs after reset until new accepts. Second frame is output-exact versus the gap-free reference model.
